// File: rtl/cache_mux_types.sv
// Shared types for the cache-side memory path: adaptor FSM states and
// address helpers used by the line/burst adaptor.
package cache_mux_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } adaptor_state_t;

  // Mask that clears the byte-offset bits of a 32-bit address.
  function automatic logic [31:0] line_mask(input int offset_bits);
    return ~((32'd1 << offset_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line held as an array of burst beats: whole-line load,
// single-beat write, and single-beat read selected by the beat index.
module line_beat_buffer #(
  parameter int s_line    = 256,
  parameter int s_beat    = 64,
  parameter int num_beats = s_line / s_beat,
  parameter int idx_w     = $clog2(num_beats)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_line,
  input  logic [s_line-1:0]      line_in,
  input  logic                   beat_we,
  input  logic [idx_w-1:0]       beat_idx,
  input  logic [s_beat-1:0]      beat_in,
  output logic [s_beat-1:0]      beat_out,
  output logic [s_line-1:0]      line_out
);

  logic [num_beats-1:0][s_beat-1:0] line_q;

  // A full-line load wins over a beat write; the FSM never asks for both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_line) begin
      line_q <= line_in;
    end else if (beat_we) begin
      line_q[beat_idx] <= beat_in;
    end
  end

  assign beat_out = line_q[beat_idx];
  assign line_out = line_q;

endmodule

// File: rtl/pmem_line_adaptor.sv
// Turns one 256-bit cache line request into a 4-beat 64-bit memory burst,
// assembling or splitting the line and answering with a one-cycle pmem_resp.
module pmem_line_adaptor
  import cache_mux_types::*;
#(
  parameter int s_offset  = 5,
  parameter int s_line    = 256,
  parameter int s_beat    = 64,
  parameter int num_beats = s_line / s_beat
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pmem_address,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [s_line-1:0]  pmem_wdata,
  output logic [s_line-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        burst_address,
  output logic               burst_read,
  output logic               burst_write,
  output logic [s_beat-1:0]  burst_wdata,
  input  logic [s_beat-1:0]  burst_rdata,
  input  logic               burst_resp
);

  localparam int cnt_w = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
  localparam logic [31:0] addr_mask = line_mask(s_offset);

  adaptor_state_t   state;
  logic [cnt_w-1:0] cnt;
  logic [31:0]      addr_q;
  logic             load_line;
  logic             beat_we;

  // Requests are only sampled in IDLE; write takes priority over read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pmem_write) begin
            addr_q <= pmem_address & addr_mask;
            cnt    <= '0;
            state  <= WRITE;
          end else if (pmem_read) begin
            addr_q <= pmem_address & addr_mask;
            cnt    <= '0;
            state  <= READ;
          end
        end
        READ, WRITE: begin
          if (burst_resp) begin
            cnt <= cnt + cnt_w'(1);
            if (cnt == last_beat) begin
              state <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load_line = (state == IDLE) && pmem_write;
  assign beat_we   = (state == READ) && burst_resp;

  line_beat_buffer #(
    .s_line    (s_line),
    .s_beat    (s_beat),
    .num_beats (num_beats),
    .idx_w     (cnt_w)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_line (load_line),
    .line_in   (pmem_wdata),
    .beat_we   (beat_we),
    .beat_idx  (cnt),
    .beat_in   (burst_rdata),
    .beat_out  (burst_wdata),
    .line_out  (pmem_rdata)
  );

  assign burst_address = addr_q;
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign pmem_resp     = (state == RESP);

endmodule
